// File: rtl/cic_pkg.sv
// ----------------------------------------------------------------------------
// cic_pkg
// Shared definitions for the CIC decimator back end: default sample width,
// the sample type, and the width of the saturating drop counter.
// ----------------------------------------------------------------------------
package cic_pkg;

   localparam int CIC_DATA_WIDTH = 20;
   localparam int DROP_CNT_W     = 8;

   typedef logic [CIC_DATA_WIDTH-1:0] cic_sample_t;

endpackage : cic_pkg

// File: rtl/cic_sync_fifo.sv
// ----------------------------------------------------------------------------
// cic_sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is always
// presented on rd_data_o while valid_o is high. A push into a full FIFO
// without a simultaneous pop is ignored and flagged on drop_o.
//
// Ports:
//   clk_i      system clock
//   rstn_i     asynchronous active-low reset
//   push_i     write wr_data_i this cycle
//   wr_data_i  sample to store
//   pop_i      consume the head entry (ignored while empty)
//   rd_data_o  head entry (mem[rd_ptr])
//   valid_o    FIFO not empty
//   level_o    number of stored entries (0..DEPTH)
//   drop_o     push_i rejected because the FIFO was full
// ----------------------------------------------------------------------------
module cic_sync_fifo
   import cic_pkg::*;
#(
   parameter int DATA_WIDTH = CIC_DATA_WIDTH,
   parameter int DEPTH      = 8
) (
   input  logic                    clk_i,
   input  logic                    rstn_i,
   input  logic                    push_i,
   input  logic [DATA_WIDTH-1:0]   wr_data_i,
   input  logic                    pop_i,
   output logic [DATA_WIDTH-1:0]   rd_data_o,
   output logic                    valid_o,
   output logic [$clog2(DEPTH):0]  level_o,
   output logic                    drop_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic                  full, empty;
   logic                  do_push, do_pop;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign do_pop  = pop_i & ~empty;
   // A pop frees the slot in the same cycle, so push-when-full still lands.
   assign do_push = push_i & (~full | do_pop);
   assign drop_o  = push_i & full & ~do_pop;

   assign wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
   assign rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Memory is cleared on reset so the idle head reads as zero.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
   assign valid_o   = ~empty;
   assign level_o   = wr_ptr_q - rd_ptr_q;

endmodule : cic_sync_fifo

// File: rtl/cic_sample_fifo.sv
// ----------------------------------------------------------------------------
// cic_sample_fifo
// Captures each decimated CIC sample on the rising edge of the low-rate
// sample strobe and buffers it in an FWFT FIFO feeding a valid/ready stream.
// Samples arriving while the FIFO is full are dropped (newest lost), which
// sets a sticky overflow flag and bumps a saturating drop counter.
//
// Ports:
//   clk_i          system clock (same as the CIC)
//   rstn_i         asynchronous active-low reset
//   sample_data_i  decimated sample, stable across the strobe rising edge
//   sample_clk_i   CIC output strobe in the clk_i domain
//   clear_i        synchronous clear of overflow_o and drop_count_o
//   m_data_o       head sample
//   m_valid_o      head sample valid
//   m_ready_i      consumer accepts the head sample
//   fill_level_o   entries currently stored
//   overflow_o     sticky, set by any dropped sample
//   drop_count_o   dropped samples, saturating at 255
// ----------------------------------------------------------------------------
module cic_sample_fifo
   import cic_pkg::*;
#(
   parameter int DATA_WIDTH = CIC_DATA_WIDTH,
   parameter int DEPTH      = 8
) (
   input  logic                   clk_i,
   input  logic                   rstn_i,
   input  logic [DATA_WIDTH-1:0]  sample_data_i,
   input  logic                   sample_clk_i,
   input  logic                   clear_i,
   output logic [DATA_WIDTH-1:0]  m_data_o,
   output logic                   m_valid_o,
   input  logic                   m_ready_i,
   output logic [$clog2(DEPTH):0] fill_level_o,
   output logic                   overflow_o,
   output logic [DROP_CNT_W-1:0]  drop_count_o
);

   logic                  sample_clk_q;
   logic                  push, pop, drop;
   logic                  overflow_q, overflow_d;
   logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   // Resetting the history to 1 suppresses a push when the strobe is
   // already high as reset releases.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sample_clk_q <= 1'b1;
      end else begin
         sample_clk_q <= sample_clk_i;
      end
   end

   assign push = sample_clk_i & ~sample_clk_q;
   assign pop  = m_valid_o & m_ready_i;

   cic_sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .push_i    (push),
      .wr_data_i (sample_data_i),
      .pop_i     (pop),
      .rd_data_o (m_data_o),
      .valid_o   (m_valid_o),
      .level_o   (fill_level_o),
      .drop_o    (drop)
   );

   // A drop in the same cycle as clear wins: the count restarts at one.
   always_comb begin
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      if (drop) begin
         overflow_d = 1'b1;
         if (clear_i) begin
            drop_cnt_d = DROP_CNT_W'(1);
         end else if (drop_cnt_q != {DROP_CNT_W{1'b1}}) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
         end
      end else if (clear_i) begin
         overflow_d = 1'b0;
         drop_cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign overflow_o   = overflow_q;
   assign drop_count_o = drop_cnt_q;

endmodule : cic_sample_fifo
